// File: rtl/cdc_sync_bank.sv
// Multi-channel synchroniser into the sysClk_i domain: flop chain, stability
// filter, single-cycle edge pulses and a sticky, clearable event flag per channel.
module cdc_sync_bank #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2,
   parameter int FILTER = 1
) (
   input  logic             sysClk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] async_i,
   input  logic [WIDTH-1:0] clear_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] rising_o,
   output logic [WIDTH-1:0] falling_o,
   output logic [WIDTH-1:0] event_o
);

   localparam int            CW       = $clog2(FILTER + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_ch
         logic [STAGES-1:0] chain_reg;
         logic              raw;
         logic              filt_reg, filt_next;
         logic [CW-1:0]     cnt_reg, cnt_next;
         logic              prev_reg;
         logic              ev_reg;
         logic              rise, fall;

         always_ff @(posedge sysClk_i or posedge reset_i) begin
            if (reset_i) begin
               chain_reg <= '0;
            end else begin
               chain_reg <= {chain_reg[STAGES-2:0], async_i[gi]};
            end
         end

         assign raw = chain_reg[STAGES-1];

         // A new level is accepted only after FILTER consecutive differing
         // cycles; any return to the current level restarts the count.
         always_comb begin
            filt_next = filt_reg;
            cnt_next  = cnt_reg;
            if (raw == filt_reg) begin
               cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
               filt_next = raw;
               cnt_next  = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         assign rise = filt_reg & ~prev_reg;
         assign fall = ~filt_reg & prev_reg;

         always_ff @(posedge sysClk_i or posedge reset_i) begin
            if (reset_i) begin
               filt_reg <= 1'b0;
               cnt_reg  <= '0;
               prev_reg <= 1'b0;
               ev_reg   <= 1'b0;
            end else begin
               filt_reg <= filt_next;
               cnt_reg  <= cnt_next;
               prev_reg <= filt_reg;
               // Set has priority over clear so no edge is ever lost.
               ev_reg   <= (ev_reg & ~clear_i[gi]) | rise | fall;
            end
         end

         assign sync_o[gi]    = filt_reg;
         assign rising_o[gi]  = rise;
         assign falling_o[gi] = fall;
         assign event_o[gi]   = ev_reg;
      end
   endgenerate

endmodule

// File: tb/tb_cdc_sync_bank.sv
// Bench for cdc_sync_bank: four instances with different STAGES/FILTER settings,
// a hand-derived vector table, corner-case sequences and a randomised model run.
module tb_cdc_sync_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a_all, c_all, s_all, r_all, f_all, e_all;

   always #5 clk = ~clk;

   // index 0: S2/F1, 1: S2/F4, 2: S2/F8, 3: S3/F2
   cdc_sync_bank #(.WIDTH(4), .STAGES(2), .FILTER(1)) dut_f1 (
      .sysClk_i(clk), .reset_i(rst), .async_i(a_all[3:0]), .clear_i(c_all[3:0]),
      .sync_o(s_all[3:0]), .rising_o(r_all[3:0]), .falling_o(f_all[3:0]), .event_o(e_all[3:0]));
   cdc_sync_bank #(.WIDTH(4), .STAGES(2), .FILTER(4)) dut_f4 (
      .sysClk_i(clk), .reset_i(rst), .async_i(a_all[7:4]), .clear_i(c_all[7:4]),
      .sync_o(s_all[7:4]), .rising_o(r_all[7:4]), .falling_o(f_all[7:4]), .event_o(e_all[7:4]));
   cdc_sync_bank #(.WIDTH(4), .STAGES(2), .FILTER(8)) dut_f8 (
      .sysClk_i(clk), .reset_i(rst), .async_i(a_all[11:8]), .clear_i(c_all[11:8]),
      .sync_o(s_all[11:8]), .rising_o(r_all[11:8]), .falling_o(f_all[11:8]), .event_o(e_all[11:8]));
   cdc_sync_bank #(.WIDTH(4), .STAGES(3), .FILTER(2)) dut_s3 (
      .sysClk_i(clk), .reset_i(rst), .async_i(a_all[15:12]), .clear_i(c_all[15:12]),
      .sync_o(s_all[15:12]), .rising_o(r_all[15:12]), .falling_o(f_all[15:12]), .event_o(e_all[15:12]));

   typedef struct packed {
      logic [3:0] a, c, s, r, f, e;
   } vec_t;

   typedef struct {
      logic [3:0] sh [3];
      logic [3:0] filt, prev, ev;
      int         run [4];
   } mstate_t;

   int          n_vec = 0;
   int          n_bad = 0;
   vec_t        tbl [24];
   logic [15:0] tq [$];
   logic [63:0] rq [$];
   mstate_t     ms [4];
   int          stg_tab [4] = '{2, 2, 2, 3};
   int          flt_tab [4] = '{1, 4, 8, 2};

   function automatic logic [15:0] obs(input int k);
      return {s_all[4*k +: 4], r_all[4*k +: 4], f_all[4*k +: 4], e_all[4*k +: 4]};
   endfunction

   function automatic vec_t mk(input logic [3:0] a, c, s, r, f, e);
      vec_t v;
      v.a = a; v.c = c; v.s = s; v.r = r; v.f = f; v.e = e;
      return v;
   endfunction

   function automatic mstate_t mzero();
      mstate_t z;
      for (int i = 0; i < 3; i++) z.sh[i] = 4'b0;
      z.filt = 4'b0; z.prev = 4'b0; z.ev = 4'b0;
      for (int ch = 0; ch < 4; ch++) z.run[ch] = 0;
      return z;
   endfunction

   // Reference behaviour for one clock edge; raw is the input seen stg edges ago.
   function automatic mstate_t mstep(input mstate_t s, input int stg, input int flt,
                                     input logic [3:0] a, input logic [3:0] c);
      mstate_t    n;
      logic [3:0] raw;
      n    = s;
      raw  = s.sh[stg-1];
      n.ev = (s.ev & ~c) | (s.filt ^ s.prev);
      n.prev = s.filt;
      for (int ch = 0; ch < 4; ch++) begin
         if (raw[ch] == s.filt[ch]) begin
            n.run[ch] = 0;
         end else if (s.run[ch] + 1 >= flt) begin
            n.filt[ch] = raw[ch];
            n.run[ch]  = 0;
         end else begin
            n.run[ch] = s.run[ch] + 1;
         end
      end
      for (int i = 2; i > 0; i--) n.sh[i] = s.sh[i-1];
      n.sh[0] = a;
      return n;
   endfunction

   function automatic logic [15:0] mexp(input mstate_t s);
      return {s.filt, s.filt & ~s.prev, ~s.filt & s.prev, s.ev};
   endfunction

   task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got s=%b r=%b f=%b e=%b, want s=%b r=%b f=%b e=%b", name,
                  got[15:12], got[11:8], got[7:4], got[3:0],
                  want[15:12], want[11:8], want[7:4], want[3:0]);
      end else begin
         $display("ok   %s: s=%b r=%b f=%b e=%b", name, got[15:12], got[11:8], got[7:4], got[3:0]);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] want;
      logic [63:0] wall;
      vec_t        v;

      tbl[0]  = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[1]  = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[2]  = mk(4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0);
      tbl[3]  = mk(4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1);
      tbl[4]  = mk(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[5]  = mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[6]  = mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[7]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
      tbl[8]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
      tbl[9]  = mk(4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
      tbl[10] = mk(4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[11] = mk(4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0);
      tbl[12] = mk(4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2);
      tbl[13] = mk(4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0);
      tbl[14] = mk(4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0);
      tbl[15] = mk(4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0);
      tbl[16] = mk(4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2);
      tbl[17] = mk(4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[18] = mk(4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[19] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[20] = mk(4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0);
      tbl[21] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4);
      tbl[22] = mk(4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 4'h4);
      tbl[23] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4);

      rst   = 1'b1;
      a_all = '0;
      c_all = '0;
      #12;
      for (int k = 0; k < 4; k++) check16($sformatf("reset_hold d%0d", k), obs(k), 16'h0);
      @(negedge clk);
      rst = 1'b0;

      // Vector table on the S2/F1 instance.
      for (int i = 0; i < 24; i++) begin
         v = tbl[i];
         a_all[3:0] = v.a;
         c_all[3:0] = v.c;
         tq.push_back({v.s, v.r, v.f, v.e});
         cyc();
         want = tq.pop_front();
         check16($sformatf("table[%0d]", i), obs(0), want);
      end

      // Asynchronous reset mid-cycle, then idle.
      a_all = '0;
      c_all = '0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) check16($sformatf("reset_async d%0d", k), obs(k), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 20; n++) begin
         cyc();
         for (int k = 0; k < 4; k++) check16($sformatf("idle c%0d d%0d", n, k), obs(k), 16'h0);
      end

      // Glitch reject on FILTER=4: raw high for three cycles only.
      a_all[7:4] = 4'h1;
      for (int n = 0; n < 11; n++) begin
         if (n == 3) a_all[7:4] = 4'h0;
         cyc();
         check16($sformatf("glitch c%0d", n), obs(1), 16'h0);
      end
      a_all[7:4] = 4'h1;
      for (int n = 0; n < 7; n++) begin
         cyc();
         want = (n == 5) ? 16'h1100 : (n == 6) ? 16'h1001 : 16'h0;
         check16($sformatf("accept4 E%0d", n), obs(1), want);
      end
      a_all[7:4] = 4'h0;

      // Mid-filter reset on FILTER=8 with the input left high through release.
      a_all[11:8] = 4'h1;
      for (int n = 0; n < 7; n++) begin
         cyc();
         check16($sformatf("prefilt8 E%0d", n), obs(2), 16'h0);
      end
      #2;
      rst = 1'b1;
      #1;
      check16("midfilt_reset", obs(2), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 11; n++) begin
         cyc();
         want = (n == 9) ? 16'h1100 : (n == 10) ? 16'h1001 : 16'h0;
         check16($sformatf("refilt8 E%0d", n), obs(2), want);
      end
      a_all = '0;

      // Depth sweep latency on STAGES=3/FILTER=2.
      pulse_reset();
      a_all[15:12] = 4'h1;
      for (int n = 0; n < 6; n++) begin
         cyc();
         want = (n == 4) ? 16'h1100 : (n == 5) ? 16'h1001 : 16'h0;
         check16($sformatf("depth3 E%0d", n), obs(3), want);
      end

      // Randomised run on all instances against the reference model.
      a_all = '0;
      c_all = '0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) ms[k] = mzero();
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 400; n++) begin
         for (int b = 0; b < 16; b++) begin
            if ($urandom_range(0, 3) == 0) a_all[b] = ~a_all[b];
            c_all[b] = ($urandom_range(0, 5) == 0);
         end
         for (int k = 0; k < 4; k++)
            ms[k] = mstep(ms[k], stg_tab[k], flt_tab[k], a_all[4*k +: 4], c_all[4*k +: 4]);
         rq.push_back({mexp(ms[3]), mexp(ms[2]), mexp(ms[1]), mexp(ms[0])});
         cyc();
         wall = rq.pop_front();
         for (int k = 0; k < 4; k++)
            check16($sformatf("rand c%0d d%0d", n, k), obs(k), wall[16*k +: 16]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
